bus_bridge: RTL and testbench
=============================

# bus_bridge

Data-side bus bridge and peripheral block directly downstream of the pipelined CPU's MEM stage. Decodes the CPU bus address, steers accesses to data RAM or to memory-mapped peripherals (LEDs, switches, 8-digit 7-segment display, timer), and returns read data in the same cycle so the MEM/WB register captures it on the next edge. All peripheral state lives here; the data RAM itself is external.

## Interface

- SCAN_DIV, 20000, clock cycles each display digit stays lit
- TIMER_DIV_RST, 32'd100, reset value of timer prescale divider
- cpu_clk  in  1  system clock, all state on rising edge
- cpu_rst  in  1  synchronous reset, active-high
- bus_addr_i  in  32  byte address from MEM stage
- bus_we_i  in  1  write strobe, single cycle per store
- bus_wdata_i  in  32  store data
- bus_rdata_o  out  32  load data, combinational from addr and registered state
- dram_addr_o  out  14  word address to data RAM (bus_addr_i[15:2])
- dram_we_o  out  1  data RAM write enable
- dram_wdata_o  out  32  data RAM write data (bus_wdata_i)
- dram_rdata_i  in  32  data RAM read data, combinational
- sw_i  in  24  board switches, asynchronous
- led_o  out  24  LED drive, active-high
- dig_en_o  out  8  digit enables, active-low, one-hot
- dig_seg_o  out  8  segments {DP,G,F,E,D,C,B,A}, active-low

## Operation

- Decode: bus_addr_i[31:12] == 20'hFFFFF selects peripheral space; everything else is DRAM.
- Peripheral map (word addresses, low 2 bits ignored): 0xFFFF_F000 display data (W/R), 0xFFFF_F020 timer count (R/W), 0xFFFF_F024 timer divider (R/W), 0xFFFF_F060 LED (W/R, bits [23:0]), 0xFFFF_F070 switches (R, zero-extended). Unmapped peripheral addresses read 0, writes ignored.
- dram_we_o = bus_we_i & ~peripheral-select; never asserted for peripheral addresses.
- bus_rdata_o = dram_rdata_i for DRAM, else selected register; no wait states.
- Switch path: two-flop synchronizer; switch read returns second stage.
- Display: 32-bit data register, digit k shows nibble [4k+3:4k] as hex 0–F (standard segment patterns, DP off). Scan counter counts 0..SCAN_DIV-1; on wrap digit index advances 0→7→0. dig_en_o = ~(1<<index).
- Timer: prescaler counts 0..divider-1; on reaching divider-1 it clears and count increments (32-bit wrap 0xFFFF_FFFF→0). Divider 0 freezes count and prescaler.
- Write to count: loads bus_wdata_i, clears prescaler; wins over same-cycle increment. Write to divider: loads value, clears prescaler.

## Timing

- Reset values: led_o 0, display data 0, dig index 0, scan counter 0, dig_en_o 8'hFE, dig_seg_o 8'hC0 (digit "0"), timer count 0, prescaler 0, divider TIMER_DIV_RST, synchronizer stages 0.
- Register writes take effect at the edge ending the bus_we_i cycle; a read of the same register in the following cycle returns the new value.
- Read data latency 0 cycles (combinational); CPU samples at next edge.
- Switch change visible on reads 2 edges after it is stable at sw_i.
- Digit display changes within one cycle of display-data write (segments decode combinationally from register and index).
- Reset asserted mid-scan or mid-count returns every register to reset value at that edge; bus_we_i ignored while cpu_rst high.

## Configuration

- TIMER_EN defined: timer count/divider registers and prescaler present as above.
- TIMER_EN undefined: no timer logic; reads of 0xFFFF_F020/0xFFFF_F024 return 0, writes ignored; all other behaviour unchanged.

## Test plan

- Store 0x1234_5678 to 0x0000_0100 -> dram_we_o=1, dram_addr_o=14'h040, dram_wdata_o=0x1234_5678; load from 0x0000_0100 with dram_rdata_i=0xCAFE_F00D -> bus_rdata_o=0xCAFE_F00D.
- Store 0x00A5_A5A5 to 0xFFFF_F060 -> dram_we_o stays 0, led_o=0xA5A5A5 next cycle; readback returns 0x00A5_A5A5.
- sw_i=0x00F0F0, load 0xFFFF_F070 -> 0 for first two cycles, 0x0000_F0F0 from third.
- Display write 0x8765_4321, SCAN_DIV=4 -> dig_en_o steps FE,FD,…,7F every 4 cycles with segments for 1,2,…,8; wraps to FE.
- Divider=3, count written 0xFFFF_FFFE -> count 0xFFFF_FFFF after 3 cycles, 0 after 6; write count 5 on an increment cycle -> reads 5; divider 0 -> count frozen.
- Assert cpu_rst mid-operation -> all outputs at reset values next edge; without TIMER_EN, timer reads return 0.

Source files
------------

// File: rtl/bus_bridge_if.sv
// ---------------------------------------------------------------------------
// bus_bridge_if
// CPU data bus plus the data-RAM side of the bridge, bundled together.
//   bus_addr_i   : byte address from the MEM stage
//   bus_we_i     : single-cycle store strobe
//   bus_wdata_i  : store data
//   bus_rdata_o  : load data (combinational)
//   dram_addr_o  : word address to data RAM
//   dram_we_o    : data RAM write enable
//   dram_wdata_o : data RAM write data
//   dram_rdata_i : data RAM read data (combinational)
// Modports: slave (the bridge), master (CPU / RAM side).
// ---------------------------------------------------------------------------
interface bus_bridge_if;
   logic [31:0] bus_addr_i;
   logic        bus_we_i;
   logic [31:0] bus_wdata_i;
   logic [31:0] bus_rdata_o;
   logic [13:0] dram_addr_o;
   logic        dram_we_o;
   logic [31:0] dram_wdata_o;
   logic [31:0] dram_rdata_i;

   modport slave (
      input  bus_addr_i, bus_we_i, bus_wdata_i, dram_rdata_i,
      output bus_rdata_o, dram_addr_o, dram_we_o, dram_wdata_o
   );

   modport master (
      output bus_addr_i, bus_we_i, bus_wdata_i, dram_rdata_i,
      input  bus_rdata_o, dram_addr_o, dram_we_o, dram_wdata_o
   );
endinterface

// File: rtl/bus_bridge.sv
// ---------------------------------------------------------------------------
// bus_bridge
// Data-side bridge below the CPU MEM stage: decodes the bus address, steers
// accesses to external data RAM or to the peripheral registers (LED,
// switches, 8-digit 7-segment display, timer) and returns read data in the
// same cycle.
//   cpu_clk   : system clock, rising edge
//   cpu_rst   : synchronous reset, active-high
//   bus       : bus_bridge_if.slave (CPU bus + data RAM port)
//   sw_i      : board switches, asynchronous
//   led_o     : LED drive, active-high
//   dig_en_o  : digit enables, active-low one-hot
//   dig_seg_o : segments {DP,G,F,E,D,C,B,A}, active-low
// Optional feature macro: TIMER_EN (timer count/divider/prescaler present).
// ---------------------------------------------------------------------------
module bus_bridge #(
   parameter int unsigned SCAN_DIV      = 20000,
   parameter logic [31:0] TIMER_DIV_RST = 32'd100
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst,
   bus_bridge_if.slave      bus,
   input  logic [23:0]      sw_i,
   output logic [23:0]      led_o,
   output logic [7:0]       dig_en_o,
   output logic [7:0]       dig_seg_o
);

   localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   // Peripheral word offsets (byte offset >> 2)
   localparam logic [9:0] OFF_DISP = 10'h000;
   localparam logic [9:0] OFF_CNT  = 10'h008;
   localparam logic [9:0] OFF_DIV  = 10'h009;
   localparam logic [9:0] OFF_LED  = 10'h018;
   localparam logic [9:0] OFF_SW   = 10'h01C;

   logic              periph_sel;
   logic [9:0]        word;
   logic              wr_periph;
   logic [31:0]       disp_data;
   logic [23:0]       sw_meta;
   logic [23:0]       sw_sync;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        dig_idx;
   logic [3:0]        nibble;
   logic [31:0]       cnt_rd;
   logic [31:0]       div_rd;
   logic [31:0]       rdata_c;
   logic [1:0]        unused_addr_lsb;

   // Address decode
   assign periph_sel      = (bus.bus_addr_i[31:12] == 20'hFFFFF);
   assign word            = bus.bus_addr_i[11:2];
   assign wr_periph       = bus.bus_we_i & periph_sel;
   assign unused_addr_lsb = bus.bus_addr_i[1:0];

   // Data RAM pass-through
   assign bus.dram_addr_o  = bus.bus_addr_i[15:2];
   assign bus.dram_we_o    = bus.bus_we_i & ~periph_sel;
   assign bus.dram_wdata_o = bus.bus_wdata_i;

   // LED and display data registers
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         led_o     <= '0;
         disp_data <= '0;
      end else begin
         if (wr_periph && word == OFF_LED)  led_o     <= bus.bus_wdata_i[23:0];
         if (wr_periph && word == OFF_DISP) disp_data <= bus.bus_wdata_i;
      end
   end

   // Two-flop switch synchronizer
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
      end
   end

   // Digit scan: enable rotates left in step with the digit index
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         scan_cnt <= '0;
         dig_idx  <= '0;
         dig_en_o <= 8'hFE;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         dig_idx  <= dig_idx + 3'd1;
         dig_en_o <= {dig_en_o[6:0], dig_en_o[7]};
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Hex to 7-segment, active-low, DP off
   assign nibble = disp_data[{dig_idx, 2'b00} +: 4];

   always_comb begin
      dig_seg_o = 8'hFF;
      case (nibble)
         4'h0: dig_seg_o = 8'hC0;
         4'h1: dig_seg_o = 8'hF9;
         4'h2: dig_seg_o = 8'hA4;
         4'h3: dig_seg_o = 8'hB0;
         4'h4: dig_seg_o = 8'h99;
         4'h5: dig_seg_o = 8'h92;
         4'h6: dig_seg_o = 8'h82;
         4'h7: dig_seg_o = 8'hF8;
         4'h8: dig_seg_o = 8'h80;
         4'h9: dig_seg_o = 8'h90;
         4'hA: dig_seg_o = 8'h88;
         4'hB: dig_seg_o = 8'h83;
         4'hC: dig_seg_o = 8'hC6;
         4'hD: dig_seg_o = 8'hA1;
         4'hE: dig_seg_o = 8'h86;
         4'hF: dig_seg_o = 8'h8E;
         default: dig_seg_o = 8'hFF;
      endcase
   end

`ifdef TIMER_EN
   logic [31:0] tmr_cnt;
   logic [31:0] tmr_div;
   logic [31:0] tmr_pre;
   logic        tmr_tick;

   // Divider 0 never matches, which freezes both prescaler and count
   assign tmr_tick = (tmr_div != 32'd0) && (tmr_pre == tmr_div - 32'd1);

   // Timer; a register write clears the prescaler and suppresses that tick
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         tmr_cnt <= '0;
         tmr_div <= TIMER_DIV_RST;
         tmr_pre <= '0;
      end else if (wr_periph && word == OFF_CNT) begin
         tmr_cnt <= bus.bus_wdata_i;
         tmr_pre <= '0;
      end else if (wr_periph && word == OFF_DIV) begin
         tmr_div <= bus.bus_wdata_i;
         tmr_pre <= '0;
      end else if (tmr_tick) begin
         tmr_pre <= '0;
         tmr_cnt <= tmr_cnt + 32'd1;
      end else if (tmr_div != 32'd0) begin
         tmr_pre <= tmr_pre + 32'd1;
      end
   end

   assign cnt_rd = tmr_cnt;
   assign div_rd = tmr_div;
`else
   assign cnt_rd = '0;
   assign div_rd = '0;
`endif

   // Read mux
   always_comb begin
      rdata_c = '0;
      if (!periph_sel) begin
         rdata_c = bus.dram_rdata_i;
      end else begin
         case (word)
            OFF_DISP: rdata_c = disp_data;
            OFF_CNT:  rdata_c = cnt_rd;
            OFF_DIV:  rdata_c = div_rd;
            OFF_LED:  rdata_c = {8'h00, led_o};
            OFF_SW:   rdata_c = {8'h00, sw_sync};
            default:  rdata_c = '0;
         endcase
      end
   end

   assign bus.bus_rdata_o = rdata_c;

endmodule

// File: tb/tb_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_bus_bridge
// Self-checking bench for bus_bridge with a cycle-level reference model of
// the peripheral registers, switch delay, display scan and timer.
// ---------------------------------------------------------------------------
module tb_bus_bridge;

   localparam int unsigned SCAN_DIV = 4;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [23:0] sw;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [7:0]  dig_seg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 cpu_clk = ~cpu_clk;

   bus_bridge_if bif ();

   bus_bridge #(.SCAN_DIV(SCAN_DIV)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .bus       (bif),
      .sw_i      (sw),
      .led_o     (led),
      .dig_en_o  (dig_en),
      .dig_seg_o (dig_seg)
   );

   // Reference model state
   logic [7:0]        seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   longint unsigned   m_cyc;
   logic [23:0]       m_led, m_sw1, m_sw2;
   logic [31:0]       m_disp, m_tbase, m_tdiv, m_cur;
   longint unsigned   m_tsince;

   // Timer value = base + whole divider periods elapsed since last clear
   function automatic logic [31:0] exp_count();
      longint unsigned q;
      if (m_tdiv == 32'd0) return m_tbase;
      q = m_tsince / 64'(m_tdiv);
      return 32'(64'(m_tbase) + q);
   endfunction

   function automatic logic [2:0] exp_idx();
      return 3'((m_cyc / 64'(SCAN_DIV)) % 64'd8);
   endfunction

   function automatic logic [7:0] exp_en();
      return ~(8'd1 << exp_idx());
   endfunction

   function automatic logic [7:0] exp_seg();
      int sh;
      sh = 4 * int'(exp_idx());
      return seg_tab[4'(m_disp >> sh)];
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      if (a[31:12] != 20'hFFFFF) return bif.dram_rdata_i;
      case ({a[11:2], 2'b00})
         12'h000: return m_disp;
         12'h060: return {8'h00, m_led};
         12'h070: return {8'h00, m_sw2};
`ifdef TIMER_EN
         12'h020: return exp_count();
         12'h024: return m_tdiv;
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Model update at each rising edge from the inputs the DUT sees
   always @(posedge cpu_clk) begin
      if (cpu_rst) begin
         m_cyc = 0; m_led = '0; m_disp = '0; m_sw1 = '0; m_sw2 = '0;
         m_tbase = '0; m_tdiv = 32'd100; m_tsince = 0;
      end else begin
         m_cur = exp_count();
         m_cyc = m_cyc + 1;
         m_sw2 = m_sw1;
         m_sw1 = sw;
         m_tsince = m_tsince + 1;
         if (bif.bus_we_i && bif.bus_addr_i[31:12] == 20'hFFFFF) begin
            case ({bif.bus_addr_i[11:2], 2'b00})
               12'h000: m_disp = bif.bus_wdata_i;
               12'h060: m_led  = bif.bus_wdata_i[23:0];
               12'h020: begin m_tbase = bif.bus_wdata_i; m_tsince = 0; end
               12'h024: begin m_tbase = m_cur; m_tdiv = bif.bus_wdata_i; m_tsince = 0; end
               default: ;
            endcase
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bif.bus_addr_i = a; bif.bus_wdata_i = d; bif.bus_we_i = 1'b1;
      step(1);
      bif.bus_we_i = 1'b0;
   endtask

   task automatic test_reset();
      cpu_rst = 1'b1;
      step(2);
      cpu_rst = 1'b0;
      n_checks++; if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led: got %h want %h", led, 24'h0); end
      n_checks++; if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL reset_dig_en: got %h want %h", dig_en, 8'hFE); end
      n_checks++; if (dig_seg !== 8'hC0) begin n_fail++; $display("FAIL reset_dig_seg: got %h want %h", dig_seg, 8'hC0); end
      bif.bus_addr_i = 32'hFFFF_F000; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_disp: got %h want %h", bif.bus_rdata_o, 32'h0); end
      bif.bus_addr_i = 32'hFFFF_F024; #1;
`ifdef TIMER_EN
      n_checks++; if (bif.bus_rdata_o !== 32'd100) begin n_fail++; $display("FAIL reset_div: got %h want %h", bif.bus_rdata_o, 32'd100); end
`else
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_div: got %h want %h", bif.bus_rdata_o, 32'h0); end
`endif
   endtask

   task automatic test_dram();
      logic [31:0] a, d, r;
      logic        we;
      bif.bus_addr_i = 32'h0000_0100; bif.bus_wdata_i = 32'h1234_5678; bif.bus_we_i = 1'b1; #1;
      n_checks++; if (bif.dram_we_o !== 1'b1) begin n_fail++; $display("FAIL dram_we: got %b want 1", bif.dram_we_o); end
      n_checks++; if (bif.dram_addr_o !== 14'h040) begin n_fail++; $display("FAIL dram_addr: got %h want 040", bif.dram_addr_o); end
      n_checks++; if (bif.dram_wdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL dram_wdata: got %h want 12345678", bif.dram_wdata_o); end
      step(1);
      bif.bus_we_i = 1'b0; bif.dram_rdata_i = 32'hCAFE_F00D; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL dram_load: got %h want cafef00d", bif.bus_rdata_o); end
      for (int i = 0; i < 16; i++) begin
         a = $urandom; d = $urandom; r = $urandom; we = 1'($urandom_range(0, 1));
         if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
         bif.bus_addr_i = a; bif.bus_wdata_i = d; bif.dram_rdata_i = r; bif.bus_we_i = we; #1;
         n_checks++; if (bif.dram_we_o !== we || bif.dram_addr_o !== a[15:2] || bif.dram_wdata_o !== d)
            begin n_fail++; $display("FAIL dram_rand: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                                     bif.dram_we_o, bif.dram_addr_o, bif.dram_wdata_o, we, a[15:2], d); end
         n_checks++; if (bif.bus_rdata_o !== r) begin n_fail++; $display("FAIL dram_rand_rd: got %h want %h", bif.bus_rdata_o, r); end
         step(1);
      end
      bif.bus_we_i = 1'b0;
   endtask

   task automatic test_led();
      logic [31:0] d;
      bif.bus_addr_i = 32'hFFFF_F060; bif.bus_wdata_i = 32'h00A5_A5A5; bif.bus_we_i = 1'b1; #1;
      n_checks++; if (bif.dram_we_o !== 1'b0) begin n_fail++; $display("FAIL led_dram_we: got %b want 0", bif.dram_we_o); end
      step(1);
      bif.bus_we_i = 1'b0; #1;
      n_checks++; if (led !== 24'hA5A5A5) begin n_fail++; $display("FAIL led_out: got %h want a5a5a5", led); end
      n_checks++; if (bif.bus_rdata_o !== 32'h00A5_A5A5) begin n_fail++; $display("FAIL led_rd: got %h want 00a5a5a5", bif.bus_rdata_o); end
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         bus_write((i % 2 == 0) ? 32'hFFFF_F060 : 32'hFFFF_F100 | 32'($urandom_range(0, 3)), d);
         bif.bus_addr_i = 32'hFFFF_F060; #1;
         n_checks++; if (led !== m_led || bif.bus_rdata_o !== exp_rdata(bif.bus_addr_i))
            begin n_fail++; $display("FAIL led_rand: got led=%h rd=%h want %h", led, bif.bus_rdata_o, m_led); end
         bif.bus_addr_i = 32'hFFFF_F100; #1;
         n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h want 0", bif.bus_rdata_o); end
      end
   endtask

   task automatic test_switch();
      sw = 24'h00F0F0; bif.bus_addr_i = 32'hFFFF_F070; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL sw_c0: got %h want 0", bif.bus_rdata_o); end
      step(1);
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL sw_c1: got %h want 0", bif.bus_rdata_o); end
      step(1);
      n_checks++; if (bif.bus_rdata_o !== 32'h0000_F0F0) begin n_fail++; $display("FAIL sw_c2: got %h want 0000f0f0", bif.bus_rdata_o); end
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 0) sw = 24'($urandom);
         #1;
         n_checks++; if (bif.bus_rdata_o !== exp_rdata(bif.bus_addr_i))
            begin n_fail++; $display("FAIL sw_rand: got %h want %h", bif.bus_rdata_o, exp_rdata(bif.bus_addr_i)); end
         step(1);
      end
   endtask

   task automatic test_display();
      bus_write(32'hFFFF_F000, 32'h8765_4321);
      bif.bus_addr_i = 32'hFFFF_F000; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'h8765_4321) begin n_fail++; $display("FAIL disp_rd: got %h want 87654321", bif.bus_rdata_o); end
      for (int i = 0; i < 48; i++) begin
         n_checks++; if (dig_en !== exp_en() || dig_seg !== exp_seg())
            begin n_fail++; $display("FAIL disp_scan: got en=%h seg=%h want en=%h seg=%h", dig_en, dig_seg, exp_en(), exp_seg()); end
         step(1);
      end
      for (int j = 0; j < 3; j++) begin
         bus_write(32'hFFFF_F000 | 32'($urandom_range(0, 3)), $urandom);
         for (int i = 0; i < 12; i++) begin
            n_checks++; if (dig_en !== exp_en() || dig_seg !== exp_seg())
               begin n_fail++; $display("FAIL disp_rand: got en=%h seg=%h want en=%h seg=%h", dig_en, dig_seg, exp_en(), exp_seg()); end
            step(1);
         end
      end
   endtask

`ifdef TIMER_EN
   task automatic test_timer();
      logic [31:0] frozen;
      bus_write(32'hFFFF_F024, 32'd3);
      bus_write(32'hFFFF_F020, 32'hFFFF_FFFE);
      bif.bus_addr_i = 32'hFFFF_F020; #1;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         n_checks++; if (bif.bus_rdata_o !== exp_count())
            begin n_fail++; $display("FAIL tmr_cnt: cycle %0d got %h want %h", k, bif.bus_rdata_o, exp_count()); end
         if (k == 3) begin
            n_checks++; if (bif.bus_rdata_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmr_c3: got %h want ffffffff", bif.bus_rdata_o); end
         end
         if (k == 6) begin
            n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tmr_wrap: got %h want 0", bif.bus_rdata_o); end
         end
      end
      // Two more edges so the next edge would be a tick; write count on it
      step(2);
      bus_write(32'hFFFF_F020, 32'd5);
      bif.bus_addr_i = 32'hFFFF_F020; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'd5) begin n_fail++; $display("FAIL tmr_wr_win: got %h want 5", bif.bus_rdata_o); end
      step(2);
      bus_write(32'hFFFF_F024, 32'd0);
      bif.bus_addr_i = 32'hFFFF_F020; #1;
      frozen = bif.bus_rdata_o;
      n_checks++; if (frozen !== exp_count()) begin n_fail++; $display("FAIL tmr_freeze0: got %h want %h", frozen, exp_count()); end
      step(10);
      n_checks++; if (bif.bus_rdata_o !== frozen || bif.bus_rdata_o !== 32'd5)
         begin n_fail++; $display("FAIL tmr_frozen: got %h want %h", bif.bus_rdata_o, 32'd5); end
      for (int j = 0; j < 6; j++) begin
         bus_write(32'hFFFF_F024, 32'($urandom_range(1, 5)));
         if (j % 2 == 0) bus_write(32'hFFFF_F020, $urandom);
         bif.bus_addr_i = 32'hFFFF_F024; #1;
         n_checks++; if (bif.bus_rdata_o !== m_tdiv) begin n_fail++; $display("FAIL tmr_div_rd: got %h want %h", bif.bus_rdata_o, m_tdiv); end
         bif.bus_addr_i = 32'hFFFF_F020; #1;
         for (int i = 0; i < 12; i++) begin
            n_checks++; if (bif.bus_rdata_o !== exp_count())
               begin n_fail++; $display("FAIL tmr_rand: got %h want %h", bif.bus_rdata_o, exp_count()); end
            step(1);
         end
      end
   endtask
`else
   task automatic test_timer();
      bus_write(32'hFFFF_F020, $urandom);
      bus_write(32'hFFFF_F024, $urandom);
      for (int i = 0; i < 4; i++) begin
         bif.bus_addr_i = (i % 2 == 0) ? 32'hFFFF_F020 : 32'hFFFF_F024; #1;
         n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tmr_absent: got %h want 0", bif.bus_rdata_o); end
         step(1);
      end
   endtask
`endif

   task automatic test_reset_mid();
      bus_write(32'hFFFF_F060, 32'h00FF_00FF);
      bus_write(32'hFFFF_F000, 32'hDEAD_BEEF);
      bus_write(32'hFFFF_F024, 32'd2);
      sw = 24'h123456;
      step(5);
      cpu_rst = 1'b1;
      bif.bus_addr_i = 32'hFFFF_F060; bif.bus_wdata_i = 32'h00FF_FFFF; bif.bus_we_i = 1'b1;
      step(1);
      cpu_rst = 1'b0; bif.bus_we_i = 1'b0; #1;
      n_checks++; if (led !== 24'h0) begin n_fail++; $display("FAIL rst_mid_led: got %h want 0", led); end
      n_checks++; if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL rst_mid_en: got %h want fe", dig_en); end
      n_checks++; if (dig_seg !== 8'hC0) begin n_fail++; $display("FAIL rst_mid_seg: got %h want c0", dig_seg); end
      bif.bus_addr_i = 32'hFFFF_F070; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_sw: got %h want 0", bif.bus_rdata_o); end
      bif.bus_addr_i = 32'hFFFF_F020; #1;
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cnt: got %h want 0", bif.bus_rdata_o); end
      bif.bus_addr_i = 32'hFFFF_F024; #1;
`ifdef TIMER_EN
      n_checks++; if (bif.bus_rdata_o !== 32'd100) begin n_fail++; $display("FAIL rst_mid_div: got %h want 64", bif.bus_rdata_o); end
`else
      n_checks++; if (bif.bus_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_div: got %h want 0", bif.bus_rdata_o); end
`endif
      for (int i = 0; i < 10; i++) begin
         step(1);
         n_checks++; if (dig_en !== exp_en() || dig_seg !== exp_seg() || led !== m_led)
            begin n_fail++; $display("FAIL rst_mid_run: got en=%h seg=%h led=%h want en=%h seg=%h led=%h",
                                     dig_en, dig_seg, led, exp_en(), exp_seg(), m_led); end
      end
   endtask

   initial begin
      cpu_rst = 1'b1;
      sw = '0;
      bif.bus_addr_i = '0; bif.bus_we_i = 1'b0; bif.bus_wdata_i = '0; bif.dram_rdata_i = '0;
      #1;
      test_reset();
      test_dram();
      test_led();
      test_switch();
      test_display();
      test_timer();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
